// File: rtl/fsm_ctrl_param.sv
// FIFO-monitor control FSM: loads and validates per-FIFO thresholds, tracks
// IDLE/ACTIVE from the empty flags and records sticky errors with a saturating entry count.
`timescale 1ns/1ps
module fsm_ctrl_param #(
  parameter int unsigned NUM_FIFOS = 5,
  parameter int unsigned THR_W     = 2,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic                       clear_err,
  input  logic [NUM_FIFOS-1:0]       fifo_errors,
  input  logic [NUM_FIFOS-1:0]       fifo_empties,
  input  logic [NUM_FIFOS*THR_W-1:0] af_i,
  input  logic [NUM_FIFOS*THR_W-1:0] ae_i,
  output logic [NUM_FIFOS-1:0]       error_out,
  output logic                       cfg_err,
  output logic [CNT_W-1:0]           err_cnt,
  output logic                       active_out,
  output logic                       idle_out,
  output logic [NUM_FIFOS*THR_W-1:0] af_o,
  output logic [NUM_FIFOS*THR_W-1:0] ae_o,
  output logic [2:0]                 state_o
);

  localparam int unsigned TW = NUM_FIFOS * THR_W;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_FIFOS-1:0] r_err, w_err_nxt;
  logic                 r_cfg, w_cfg_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_idle, w_idle_nxt;
  logic                 r_active, w_active_nxt;
  logic [TW-1:0]        r_af, w_af_nxt;
  logic [TW-1:0]        r_ae, w_ae_nxt;
  logic                 w_cfg_bad;
  logic                 w_any_err;
  logic                 w_all_empty;

  assign w_any_err   = |fifo_errors;
  assign w_all_empty = &fifo_empties;

  // A threshold pair is unusable when almost-empty is not strictly below almost-full.
  always_comb begin
    w_cfg_bad = 1'b0;
    for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
      if (ae_i[k*THR_W +: THR_W] >= af_i[k*THR_W +: THR_W]) w_cfg_bad = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_cfg_nxt   = r_cfg;
    w_cnt_nxt   = r_cnt;
    w_af_nxt    = r_af;
    w_ae_nxt    = r_ae;
    case (r_state)
      S_RESET: w_state_nxt = S_INIT;
      S_INIT: begin
        w_af_nxt  = af_i;
        w_ae_nxt  = ae_i;
        w_err_nxt = r_err | fifo_errors;
        if (w_any_err)      w_state_nxt = S_ERROR;
        else if (init)      w_state_nxt = S_INIT;
        else if (w_cfg_bad) begin
          w_state_nxt = S_ERROR;
          w_cfg_nxt   = 1'b1;
        end
        else                w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        w_err_nxt = r_err | fifo_errors;
        if (w_any_err)         w_state_nxt = S_ERROR;
        else if (init)         w_state_nxt = S_INIT;
        else if (!w_all_empty) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        w_err_nxt = r_err | fifo_errors;
        if (w_any_err)        w_state_nxt = S_ERROR;
        else if (init)        w_state_nxt = S_INIT;
        else if (w_all_empty) w_state_nxt = S_IDLE;
      end
      S_ERROR: begin
        if (clear_err && !w_any_err) begin
          w_state_nxt = S_INIT;
          w_err_nxt   = '0;
          w_cfg_nxt   = 1'b0;
        end else begin
          w_err_nxt = r_err | fifo_errors;
        end
      end
      default: w_state_nxt = S_RESET;
    endcase
    if ((w_state_nxt == S_ERROR) && (r_state != S_ERROR) && (r_cnt != {CNT_W{1'b1}}))
      w_cnt_nxt = r_cnt + CNT_W'(1);
    w_idle_nxt   = (w_state_nxt == S_IDLE);
    w_active_nxt = (w_state_nxt == S_ACTIVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_RESET;
      r_err    <= '0;
      r_cfg    <= 1'b0;
      r_cnt    <= '0;
      r_idle   <= 1'b0;
      r_active <= 1'b0;
      r_af     <= '0;
      r_ae     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_err    <= w_err_nxt;
      r_cfg    <= w_cfg_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idle   <= w_idle_nxt;
      r_active <= w_active_nxt;
      r_af     <= w_af_nxt;
      r_ae     <= w_ae_nxt;
    end
  end

  assign state_o    = r_state;
  assign error_out  = r_err;
  assign cfg_err    = r_cfg;
  assign err_cnt    = r_cnt;
  assign idle_out   = r_idle;
  assign active_out = r_active;
  assign af_o       = r_af;
  assign ae_o       = r_ae;

endmodule

// File: tb/tb_fsm_ctrl_param.sv
// Bench for fsm_ctrl_param: directed vector table, async-reset and saturation
// sequences, then randomized traffic against a rule-level reference model.
`timescale 1ns/1ps
module tb_fsm_ctrl_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic       clear_err;
  logic [4:0] fifo_errors;
  logic [4:0] fifo_empties;
  logic [9:0] af_i;
  logic [9:0] ae_i;
  logic [4:0] error_out;
  logic       cfg_err;
  logic [3:0] err_cnt;
  logic       active_out;
  logic       idle_out;
  logic [9:0] af_o;
  logic [9:0] ae_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model, using the documented state codes
  int         m_state;
  logic [4:0] m_err;
  logic       m_cfg;
  int         m_cnt;
  logic [9:0] m_af, m_ae;

  fsm_ctrl_param #(.NUM_FIFOS(5), .THR_W(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .init(init), .clear_err(clear_err),
    .fifo_errors(fifo_errors), .fifo_empties(fifo_empties),
    .af_i(af_i), .ae_i(ae_i), .error_out(error_out), .cfg_err(cfg_err),
    .err_cnt(err_cnt), .active_out(active_out), .idle_out(idle_out),
    .af_o(af_o), .ae_o(ae_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       init, clr;
    logic [4:0] errs, emps;
    logic [9:0] af, ae;
    logic [2:0] st;
    logic [4:0] eo;
    logic [3:0] cnt;
    logic       cfg, idl, act;
    logic [9:0] afo, aeo;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_err = '0; m_cfg = 1'b0; m_cnt = 0; m_af = '0; m_ae = '0;
  endtask

  function automatic bit thr_bad(input logic [9:0] af, input logic [9:0] ae);
    for (int k = 0; k < 5; k++)
      if (((ae >> (2*k)) & 10'd3) >= ((af >> (2*k)) & 10'd3)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    int nxt;
    if (reset) begin model_reset(); return; end
    nxt = m_state;
    if (m_state == 0) nxt = 1;
    else if (m_state == 4) begin
      if (clear_err && fifo_errors == 0) begin nxt = 1; m_err = '0; m_cfg = 1'b0; end
      else m_err = m_err | fifo_errors;
    end else if (m_state >= 1 && m_state <= 3) begin
      m_err = m_err | fifo_errors;
      if (m_state == 1) begin m_af = af_i; m_ae = ae_i; end
      if (fifo_errors != 0) nxt = 4;
      else if (init) nxt = 1;
      else if (m_state == 1) begin
        if (thr_bad(af_i, ae_i)) begin nxt = 4; m_cfg = 1'b1; end
        else nxt = 2;
      end
      else if (m_state == 2) nxt = (fifo_empties != 5'h1F) ? 3 : 2;
      else nxt = (fifo_empties == 5'h1F) ? 2 : 3;
    end else nxt = 0;
    if (nxt == 4 && m_state != 4 && m_cnt < 15) m_cnt++;
    m_state = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".state"},  32'(state_o),    32'(m_state));
    chk({tag, ".err"},    32'(error_out),  32'(m_err));
    chk({tag, ".cnt"},    32'(err_cnt),    32'(m_cnt));
    chk({tag, ".cfg"},    32'(cfg_err),    32'(m_cfg));
    chk({tag, ".idle"},   32'(idle_out),   32'(m_state == 2));
    chk({tag, ".active"}, 32'(active_out), 32'(m_state == 3));
    chk({tag, ".af_o"},   32'(af_o),       32'(m_af));
    chk({tag, ".ae_o"},   32'(ae_o),       32'(m_ae));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".zero"}, {2'b0, state_o, error_out, cfg_err, err_cnt, active_out, idle_out, 16'b0}, 32'd0);
    chk({tag, ".afae"}, {12'b0, af_o, ae_o}, 32'd0);
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 5'h00, 5'h1F, 10'h2AA, 10'h155, 3'd1, 5'h00, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000};
    vt[1]  = '{1'b0, 1'b0, 5'h00, 5'h1F, 10'h2AA, 10'h155, 3'd2, 5'h00, 4'd0, 1'b0, 1'b1, 1'b0, 10'h2AA, 10'h155};
    vt[2]  = '{1'b0, 1'b0, 5'h00, 5'h01, 10'h2AA, 10'h155, 3'd3, 5'h00, 4'd0, 1'b0, 1'b0, 1'b1, 10'h2AA, 10'h155};
    vt[3]  = '{1'b0, 1'b0, 5'h00, 5'h01, 10'h2AA, 10'h155, 3'd3, 5'h00, 4'd0, 1'b0, 1'b0, 1'b1, 10'h2AA, 10'h155};
    vt[4]  = '{1'b0, 1'b0, 5'h00, 5'h1F, 10'h2AA, 10'h155, 3'd2, 5'h00, 4'd0, 1'b0, 1'b1, 1'b0, 10'h2AA, 10'h155};
    vt[5]  = '{1'b0, 1'b0, 5'h00, 5'h01, 10'h2AA, 10'h155, 3'd3, 5'h00, 4'd0, 1'b0, 1'b0, 1'b1, 10'h2AA, 10'h155};
    vt[6]  = '{1'b0, 1'b0, 5'h11, 5'h01, 10'h2AA, 10'h155, 3'd4, 5'h11, 4'd1, 1'b0, 1'b0, 1'b0, 10'h2AA, 10'h155};
    vt[7]  = '{1'b1, 1'b0, 5'h04, 5'h01, 10'h2AA, 10'h155, 3'd4, 5'h15, 4'd1, 1'b0, 1'b0, 1'b0, 10'h2AA, 10'h155};
    vt[8]  = '{1'b0, 1'b1, 5'h02, 5'h01, 10'h2AA, 10'h155, 3'd4, 5'h17, 4'd1, 1'b0, 1'b0, 1'b0, 10'h2AA, 10'h155};
    vt[9]  = '{1'b0, 1'b1, 5'h00, 5'h01, 10'h2AA, 10'h155, 3'd1, 5'h00, 4'd1, 1'b0, 1'b0, 1'b0, 10'h2AA, 10'h155};
    vt[10] = '{1'b0, 1'b0, 5'h00, 5'h1F, 10'h29A, 10'h175, 3'd4, 5'h00, 4'd2, 1'b1, 1'b0, 1'b0, 10'h29A, 10'h175};
    vt[11] = '{1'b1, 1'b0, 5'h00, 5'h1F, 10'h3FF, 10'h000, 3'd4, 5'h00, 4'd2, 1'b1, 1'b0, 1'b0, 10'h29A, 10'h175};
    vt[12] = '{1'b0, 1'b1, 5'h00, 5'h1F, 10'h3FF, 10'h000, 3'd1, 5'h00, 4'd2, 1'b0, 1'b0, 1'b0, 10'h29A, 10'h175};
    vt[13] = '{1'b0, 1'b0, 5'h00, 5'h1F, 10'h3FF, 10'h000, 3'd2, 5'h00, 4'd2, 1'b0, 1'b1, 1'b0, 10'h3FF, 10'h000};

    // reset held with busy inputs: everything must read zero
    reset = 1'b1; init = 1'b1; clear_err = 1'b1; fifo_errors = 5'h1F;
    fifo_empties = 5'h00; af_i = 10'h3FF; ae_i = 10'h3FF;
    model_reset();
    step(); step();
    chk_zero("reset_hold");

    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      init = vt[i].init; clear_err = vt[i].clr; fifo_errors = vt[i].errs;
      fifo_empties = vt[i].emps; af_i = vt[i].af; ae_i = vt[i].ae;
      step();
      chk($sformatf("vec%0d.state", i),  32'(state_o),    32'(vt[i].st));
      chk($sformatf("vec%0d.err", i),    32'(error_out),  32'(vt[i].eo));
      chk($sformatf("vec%0d.cnt", i),    32'(err_cnt),    32'(vt[i].cnt));
      chk($sformatf("vec%0d.cfg", i),    32'(cfg_err),    32'(vt[i].cfg));
      chk($sformatf("vec%0d.idle", i),   32'(idle_out),   32'(vt[i].idl));
      chk($sformatf("vec%0d.active", i), 32'(active_out), 32'(vt[i].act));
      chk($sformatf("vec%0d.af_o", i),   32'(af_o),       32'(vt[i].afo));
      chk($sformatf("vec%0d.ae_o", i),   32'(ae_o),       32'(vt[i].aeo));
    end

    // async reset landing between edges while ACTIVE
    fifo_empties = 5'h01; init = 1'b0; clear_err = 1'b0; fifo_errors = 5'h00;
    step();
    chk("mid_active.state", 32'(state_o), 32'd3);
    #3 reset = 1'b1;
    #1;
    chk_zero("async_reset");
    model_reset();
    step();
    chk_zero("async_reset_edge");

    // 17 entries into ERROR: counter must stop at 15
    reset = 1'b0; af_i = 10'h2AA; ae_i = 10'h155; fifo_empties = 5'h1F;
    step();
    chk("sat_init.state", 32'(state_o), 32'd1);
    for (int i = 0; i < 17; i++) begin
      fifo_errors = 5'h01; clear_err = 1'b0;
      step();
      chk($sformatf("sat%0d.state", i), 32'(state_o), 32'd4);
      chk($sformatf("sat%0d.cnt", i), 32'(err_cnt), 32'((i + 1 > 15) ? 15 : i + 1));
      fifo_errors = 5'h00; clear_err = 1'b1;
      step();
    end
    chk("sat_final.cnt", 32'(err_cnt), 32'd15);
    clear_err = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 60) == 0);
      init        = ($urandom_range(0, 7) == 0);
      clear_err   = ($urandom_range(0, 2) == 0);
      fifo_errors = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'h00;
      fifo_empties = ($urandom_range(0, 2) == 0) ? 5'h1F : 5'($urandom);
      if ($urandom_range(0, 1) == 0) begin af_i = 10'h2AA; ae_i = 10'h155; end
      else begin af_i = 10'($urandom); ae_i = 10'($urandom); end
      step();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fsm_ctrl_param.md
FSM_CTRL_PARAM -- requirements
Module: fsm_ctrl_param

Parameters
REQ-001 SHALL provide NUM_FIFOS, default 5, the number of monitored FIFOs.
REQ-002 SHALL provide THR_W, default 2, the width of each per-FIFO threshold field.
REQ-003 SHALL provide CNT_W, default 4, the width of the saturating error-event counter.

Interface
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 init  input  1  request to (re)load thresholds.
REQ-007 clear_err  input  1  request to leave ERROR.
REQ-008 fifo_errors  input  NUM_FIFOS  per-FIFO error flags.
REQ-009 fifo_empties  input  NUM_FIFOS  per-FIFO empty flags.
REQ-010 af_i  input  NUM_FIFOS*THR_W  almost-full thresholds; FIFO k occupies bits [k*THR_W +: THR_W].
REQ-011 ae_i  input  NUM_FIFOS*THR_W  almost-empty thresholds, packed the same way.
REQ-012 error_out  output  NUM_FIFOS  sticky per-FIFO error record.
REQ-013 cfg_err  output  1  sticky flag: a loaded threshold pair is invalid.
REQ-014 err_cnt  output  CNT_W  count of entries into ERROR.
REQ-015 active_out  output  1  high while in state ACTIVE.
REQ-016 idle_out  output  1  high while in state IDLE.
REQ-017 af_o  output  NUM_FIFOS*THR_W  captured almost-full thresholds.
REQ-018 ae_o  output  NUM_FIFOS*THR_W  captured almost-empty thresholds.
REQ-019 state_o  output  3  current state code.

Function
REQ-020 SHALL be a Moore FSM with all outputs registered; outputs change only on a rising clk edge or on reset.
REQ-021 SHALL use these state codes: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; codes 5-7 SHALL go to RESET on the next edge.
REQ-022 From RESET, SHALL go to INIT on the first edge after reset deasserts.
REQ-023 In INIT, SHALL copy af_i/ae_i into af_o/ae_o on every edge while in INIT, including the edge that leaves INIT.
REQ-024 SHALL leave INIT when init=0: to ERROR with cfg_err=1 if any FIFO has ae_i >= af_i (unsigned, per field) on that edge, otherwise to IDLE.
REQ-025 In IDLE, SHALL go to ACTIVE if fifo_empties is not all ones, else stay in IDLE.
REQ-026 In ACTIVE, SHALL go to IDLE if fifo_empties is all ones, else stay in ACTIVE.
REQ-027 Priority in INIT, IDLE and ACTIVE SHALL be: fifo_errors!=0 → ERROR; else init=1 → INIT; else the state's own rule.
REQ-028 On each edge with state in INIT, IDLE or ACTIVE, error_out SHALL be updated to error_out OR fifo_errors.
REQ-029 In ERROR, SHALL ignore init and keep OR-accumulating fifo_errors into error_out.
REQ-030 SHALL go from ERROR to INIT when clear_err=1 and fifo_errors=0; that edge SHALL clear error_out and cfg_err.
REQ-031 If clear_err=1 while fifo_errors!=0, SHALL stay in ERROR.
REQ-032 err_cnt SHALL increment on each transition into ERROR, SHALL saturate at 2^CNT_W-1, and SHALL NOT be cleared by clear_err.
REQ-033 idle_out and active_out SHALL be mutually exclusive and SHALL both be 0 in RESET, INIT and ERROR.
REQ-034 af_o/ae_o SHALL hold their values outside INIT, including in ERROR.

Reset
REQ-035 While reset=1, SHALL hold state RESET and drive every output to 0, including af_o, ae_o, err_cnt and cfg_err.
REQ-036 Reset asserted mid-operation SHALL take effect immediately (asynchronously) from any state; the sequence SHALL restart at REQ-022 after release.

Verification (NUM_FIFOS=5, THR_W=2)
REQ-037 Sequence: reset, release, init for 1 cycle with af=0b1010101010, ae=0b0101010101 → state_o 0,1,2; af_o/ae_o equal the inputs; idle_out=1.
REQ-038 From IDLE, fifo_empties=0b00001 for 2 cycles, then 0b11111 → active_out=1 for 2 cycles, then idle_out=1.
REQ-039 In ACTIVE, fifo_errors=0b10001 for 1 cycle, then 0b00100 → state ERROR, error_out=0b10101, err_cnt=1; init=1 ignored.
REQ-040 In ERROR, clear_err=1 with fifo_errors=0b00010 → stays in ERROR; clear_err=1 with fifo_errors=0 → INIT, error_out=0, err_cnt stays 1.
REQ-041 Load a FIFO-2 field with ae=3, af=1 → after init falls, state ERROR, cfg_err=1, af_o/ae_o hold the loaded values.
REQ-042 Assert reset mid-ACTIVE and between edges → all outputs 0 immediately; force 17 error entries with CNT_W=4 → err_cnt saturates at 15.
